// File: rtl/freq_sel_pkg.sv
// Shared constants and types for the frequency-select sequencer.
// FSM encodings are plain localparams so legacy code can compare against them directly.
package freq_sel_pkg;

  localparam int unsigned FREQ_W = 32;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE_A = 2'd1;
  localparam logic [1:0] ISSUE_B = 2'd2;
  localparam logic [1:0] DRAIN   = 2'd3;

  localparam logic TAG_FIRST  = 1'b0;
  localparam logic TAG_SECOND = 1'b1;

  typedef struct packed {
    logic              last;
    logic              tag;
    logic [FREQ_W-1:0] data;
  } buf_entry_t;

endpackage

// File: rtl/freq_seq_fifo.sv
// Synchronous elastic buffer with occupancy count; head is read combinationally.
// Storage is cleared on reset so the stream outputs start at zero.
module freq_seq_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             full, push, pull;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = wr_en & ~full;
  assign pull  = rd_en & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr_q] <= wr_data;
        wr_ptr_q      <= wr_ptr_q + 1'b1;
      end
      if (pull) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pull};
    end
  end

  assign rd_data = mem[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/freq_select_sequencer.sv
// Pops programmed word counts from the selector's two lists and streams them out tagged by list.
// Optional FREQ_SEQ_CNT_EN adds frame_cnt / stall_cnt statistics outputs.
module freq_select_sequencer
  import freq_sel_pkg::*;
#(
  parameter int unsigned DATA_W    = FREQ_W,
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic              dev_clk,
  input  logic              dev_rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_first,
  input  logic [CNT_W-1:0]  num_second,
  output logic              rd_en_first,
  output logic              rd_en_second,
  input  logic [DATA_W-1:0] din,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tuser,
  output logic              m_tlast,
  output logic              busy,
  output logic              done
`ifdef FREQ_SEQ_CNT_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int unsigned OCC_W = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned SUM_W = OCC_W + 2;
  localparam int unsigned ENT_W = DATA_W + 2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] rem_a_q, rem_a_d, rem_b_q, rem_b_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [RD_LAT-1:0] pv_q, ptag_q, plast_q;

  logic             issue_a, issue_b, credit_ok, pop, pop_last, beat, start_acc;
  logic [SUM_W-1:0] in_flight;
  logic [OCC_W-1:0] occ;
  logic             fifo_empty;
  logic [ENT_W-1:0] head;

  assign issue_a   = (state_q == ISSUE_A);
  assign issue_b   = (state_q == ISSUE_B);
  assign beat      = m_tvalid & m_tready;
  assign start_acc = start & (state_q == IDLE) & ~busy_q;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < int'(RD_LAT); i++) in_flight = in_flight + SUM_W'(pv_q[i]);
  end

  // A beat leaving this cycle frees a slot for a pop issued this cycle.
  assign credit_ok    = (SUM_W'(occ) + in_flight) < (SUM_W'(BUF_DEPTH) + SUM_W'(beat));
  assign rd_en_first  = issue_a & credit_ok;
  assign rd_en_second = issue_b & credit_ok;
  assign pop          = rd_en_first | rd_en_second;
  assign pop_last     = issue_b ? (rem_b_q == CNT_W'(1))
                                : ((rem_a_q == CNT_W'(1)) && (rem_b_q == '0));

  always_comb begin
    state_d = state_q;
    rem_a_d = rem_a_q;
    rem_b_d = rem_b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start_acc) begin
          rem_a_d = num_first;
          rem_b_d = num_second;
          busy_d  = 1'b1;
          // Empty frame: one busy cycle with done, no pops and no beats.
          if (num_first == '0 && num_second == '0) done_d = 1'b1;
          else if (num_first == '0)                 state_d = ISSUE_B;
          else                                      state_d = ISSUE_A;
        end
      end
      ISSUE_A: begin
        if (pop) begin
          rem_a_d = rem_a_q - CNT_W'(1);
          if (rem_a_q == CNT_W'(1)) state_d = (rem_b_q == '0) ? DRAIN : ISSUE_B;
        end
      end
      ISSUE_B: begin
        if (pop) begin
          rem_b_d = rem_b_q - CNT_W'(1);
          if (rem_b_q == CNT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (beat && m_tlast) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge dev_clk or posedge dev_rst) begin
    if (dev_rst) begin
      state_q <= IDLE;
      rem_a_q <= '0;
      rem_b_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pv_q    <= '0;
      ptag_q  <= '0;
      plast_q <= '0;
    end else begin
      state_q    <= state_d;
      rem_a_q    <= rem_a_d;
      rem_b_q    <= rem_b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pv_q[0]    <= pop;
      ptag_q[0]  <= issue_b ? TAG_SECOND : TAG_FIRST;
      plast_q[0] <= pop_last;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        pv_q[i]    <= pv_q[i-1];
        ptag_q[i]  <= ptag_q[i-1];
        plast_q[i] <= plast_q[i-1];
      end
    end
  end

  freq_seq_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk     (dev_clk),
    .rst     (dev_rst),
    .wr_en   (pv_q[RD_LAT-1]),
    .wr_data ({plast_q[RD_LAT-1], ptag_q[RD_LAT-1], din}),
    .rd_en   (beat),
    .rd_data (head),
    .empty   (fifo_empty),
    .count   (occ)
  );

  assign m_tvalid = ~fifo_empty;
  assign m_tlast  = head[ENT_W-1];
  assign m_tuser  = head[ENT_W-2];
  assign m_tdata  = head[DATA_W-1:0];
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef FREQ_SEQ_CNT_EN
  logic [15:0] frame_cnt_q, stall_cnt_q;

  always_ff @(posedge dev_clk or posedge dev_rst) begin
    if (dev_rst) begin
      frame_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (done_d) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (start_acc) stall_cnt_q <= '0;
      else if (m_tvalid && !m_tready && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_freq_select_sequencer.sv
// Bench for freq_select_sequencer: two instances (RD_LAT 1 and 3) share stimulus; each has a
// selector model feeding din and a scoreboard that derives the expected stream from the lists.
module tb_freq_select_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, m_tready, new_frame;
  logic [9:0] num_first, num_second;

  logic [1:0] rd_a_w, rd_b_w, valid_w, user_w, last_w, busy_w, done_w;

  logic [31:0] list_a [1024];
  logic [31:0] list_b [1024];
  int nf, nb;
  int cyc_n = 0;
  int n_pass = 0, n_total = 0;

  int busy_cnt [2], done_cnt [2], pop_cnt [2], valid_cnt [2], fv [2];
  int hcnt;
  logic [1:0] hist [16];
  logic [1:0] done_seen;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int unsigned LAT = (g == 0) ? 1 : 3;
    logic [31:0] din, tdata, nxt_word;
    logic [31:0] dline [4];
    int ia, ib, beat, outst, last_hs;
    logic stall;
    logic [33:0] prev, obsv, expv;
`ifdef FREQ_SEQ_CNT_EN
    logic [15:0] fcnt, scnt;
`endif

    freq_select_sequencer #(
      .DATA_W    (32),
      .CNT_W     (10),
      .RD_LAT    (LAT),
      .BUF_DEPTH (4)
    ) u_dut (
      .dev_clk      (clk),
      .dev_rst      (rst),
      .start        (start),
      .num_first    (num_first),
      .num_second   (num_second),
      .rd_en_first  (rd_a_w[g]),
      .rd_en_second (rd_b_w[g]),
      .din          (din),
      .m_tvalid     (valid_w[g]),
      .m_tready     (m_tready),
      .m_tdata      (tdata),
      .m_tuser      (user_w[g]),
      .m_tlast      (last_w[g]),
      .busy         (busy_w[g]),
      .done         (done_w[g])
`ifdef FREQ_SEQ_CNT_EN
      ,
      .frame_cnt    (fcnt),
      .stall_cnt    (scnt)
`endif
    );

    // Selector model: the word popped in a cycle appears on din LAT cycles later.
    assign din = dline[LAT-1];
    always @(posedge clk) begin
      dline[0] <= nxt_word;
      for (int i = 1; i < 4; i++) dline[i] <= dline[i-1];
    end

    always @(negedge clk) begin
      if (rst) begin
        ia = 0; ib = 0; beat = 0; outst = 0; last_hs = 0;
        stall = 1'b0;
        nxt_word = $urandom;
      end else begin
        if (new_frame) begin
          ia = 0; ib = 0; beat = 0;
        end
        if (rd_a_w[g] || rd_b_w[g]) chk("rd_exclusive", rd_a_w[g] & rd_b_w[g], 1'b0);
        if (rd_a_w[g]) begin
          chk("pop_first_in_range", ia < nf, 1'b1);
          nxt_word = (ia < 1024) ? list_a[ia] : 32'h0;
          ia++;
        end else if (rd_b_w[g]) begin
          chk("pop_second_in_range", ib < nb, 1'b1);
          nxt_word = (ib < 1024) ? list_b[ib] : 32'h0;
          ib++;
        end else begin
          nxt_word = $urandom;
        end
        obsv = {last_w[g], user_w[g], tdata};
        if (stall) begin
          chk("hold_valid", valid_w[g], 1'b1);
          chk("hold_head", obsv, prev);
        end
        if (valid_w[g] && m_tready) begin
          chk("beat_in_range", beat < nf + nb, 1'b1);
          if (beat < nf)           expv = {beat == nf + nb - 1, 1'b0, list_a[beat]};
          else if (beat < nf + nb) expv = {beat == nf + nb - 1, 1'b1, list_b[beat-nf]};
          else                     expv = '0;
          chk("beat_word", obsv, expv);
          beat++;
          last_hs = cyc_n;
        end
        if (done_w[g]) begin
          chk("done_beats", beat, nf + nb);
          if (nf + nb > 0) chk("done_latency", cyc_n - last_hs, 1);
        end
        outst = outst + int'(rd_a_w[g] | rd_b_w[g]) - int'(valid_w[g] & m_tready);
        if (rd_a_w[g] || rd_b_w[g]) chk("occupancy_bound", outst <= 4, 1'b1);
        stall = valid_w[g] & ~m_tready;
        prev  = obsv;
      end
    end
  end

  task automatic clear_acc();
    for (int g = 0; g < 2; g++) begin
      busy_cnt[g] = 0; done_cnt[g] = 0; pop_cnt[g] = 0; valid_cnt[g] = 0; fv[g] = -1;
    end
    hcnt = 0;
    done_seen = 2'b00;
  endtask

  task automatic cyc();
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      busy_cnt[g]  += int'(busy_w[g]);
      done_cnt[g]  += int'(done_w[g]);
      pop_cnt[g]   += int'(rd_a_w[g] | rd_b_w[g]);
      valid_cnt[g] += int'(valid_w[g]);
      if (fv[g] < 0 && valid_w[g]) fv[g] = hcnt;
    end
    if (hcnt < 16) hist[hcnt] = {rd_b_w[0], rd_a_w[0]};
    hcnt++;
    done_seen |= done_w;
    @(posedge clk);
    #1;
  endtask

  task automatic begin_frame(input int f, input int s);
    for (int i = 0; i < f; i++) list_a[i] = $urandom;
    for (int i = 0; i < s; i++) list_b[i] = $urandom;
    nf = f;
    nb = s;
    num_first  = f[9:0];
    num_second = s[9:0];
    clear_acc();
    start = 1'b1;
    new_frame = 1'b1;
    cyc();
    start = 1'b0;
    new_frame = 1'b0;
  endtask

  // mode 0: ready high, 1: random ready, 2: toggling ready
  task automatic wait_done(input int mode, input int budget);
    int n = 0;
    while (done_seen != 2'b11 && n < budget) begin
      case (mode)
        0:       m_tready = 1'b1;
        1:       m_tready = 1'($urandom_range(0, 1));
        default: m_tready = ~m_tready;
      endcase
      cyc();
      n++;
    end
    chk("frame_complete", done_seen, 2'b11);
    m_tready = 1'b1;
  endtask

  initial begin
    logic [1:0] exp_hist [7];
    int n;
    exp_hist = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00};
    rst = 1'b1; start = 1'b0; new_frame = 1'b0; m_tready = 1'b1;
    num_first = '0; num_second = '0; nf = 0; nb = 0;
    clear_acc();
    repeat (3) cyc();
    chk("reset_outputs", {rd_a_w, rd_b_w, valid_w, user_w, last_w, busy_w, done_w}, 14'h0);
    chk("reset_tdata", {g_lane[0].tdata, g_lane[1].tdata}, 64'h0);
    rst = 1'b0;
    repeat (2) cyc();

    // 3 + 2 words, ready held high
    begin_frame(3, 2);
    wait_done(0, 100);
    for (int i = 0; i < 7; i++) chk("pop_pattern", hist[i], exp_hist[i]);
    chk("first_valid_lat1", fv[0], 3);
    chk("first_valid_lat3", fv[1], 5);
    repeat (2) cyc();

    // empty frame
    begin_frame(0, 0);
    repeat (4) cyc();
    for (int g = 0; g < 2; g++) begin
      chk("empty_busy_cycles", busy_cnt[g], 1);
      chk("empty_done_pulses", done_cnt[g], 1);
      chk("empty_pops", pop_cnt[g], 0);
      chk("empty_valid", valid_cnt[g], 0);
    end

    // backpressure: 16 words, ready low for 10 cycles
    m_tready = 1'b0;
    begin_frame(16, 0);
    repeat (9) cyc();
    chk("stalled_pops_lat1", pop_cnt[0], 4);
    chk("stalled_pops_lat3", pop_cnt[1], 4);
    wait_done(0, 200);
    repeat (2) cyc();

    // toggling ready
    begin_frame(7, 9);
    wait_done(2, 500);
    repeat (2) cyc();

    // start while busy is ignored
    begin_frame(5, 3);
    repeat (2) cyc();
    num_first = 10'd9; num_second = 10'd9; start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done(0, 200);
    repeat (3) cyc();
    chk("busy_start_done_lat1", done_cnt[0], 1);
    chk("busy_start_done_lat3", done_cnt[1], 1);

    // reset during ISSUE_B
    begin_frame(2, 20);
    n = 0;
    while (!rd_b_w[0] && n < 20) begin
      cyc();
      n++;
    end
    chk("reached_issue_b", rd_b_w[0], 1'b1);
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", {rd_a_w, rd_b_w, valid_w, user_w, last_w, busy_w, done_w}, 14'h0);
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    begin_frame(1, 0);
    wait_done(0, 100);
    chk("post_reset_words_lat1", valid_cnt[0], 1);
    chk("post_reset_words_lat3", valid_cnt[1], 1);
    repeat (2) cyc();

    // random frames with random backpressure
    for (int r = 0; r < 6; r++) begin
      begin_frame(int'($urandom_range(0, 12)), int'($urandom_range(0, 12)));
      wait_done(1, 3000);
      repeat (2) cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
